// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, constants and bit-mixing functions for the two-block engine.
package sha256_pkg;

  typedef logic [31:0]        word_t;
  typedef logic [0:7][31:0]   hvec_t;   // index 0 = a / H0, sits in the MSBs
  typedef logic [0:15][31:0]  sched_t;  // index 0 = W_t of the current round

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN0,
    ST_ADD0,
    ST_RUN1,
    ST_ADD1,
    ST_DONE
  } state_e;

  localparam hvec_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t ch(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic word_t maj(input word_t x, input word_t y, input word_t z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_two_block_if.sv
// Valid/ready request (1024-bit padded message) and response (256-bit digest) bundle.
interface sha256_two_block_if;
  logic          in_valid;
  logic [1023:0] in;
  logic          in_ready;
  logic          out_valid;
  logic [255:0]  out;
  logic          out_ready;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out
  );
endinterface

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: (a..h, K_t, W_t) -> next a..h.
module sha256_round
  import sha256_pkg::*;
(
  input  hvec_t st_i,
  input  word_t k_i,
  input  word_t w_i,
  output hvec_t st_o
);
  word_t t1;
  word_t t2;

  always_comb begin
    t1   = st_i[7] + big_sigma1(st_i[4]) + ch(st_i[4], st_i[5], st_i[6]) + k_i + w_i;
    t2   = big_sigma0(st_i[0]) + maj(st_i[0], st_i[1], st_i[2]);
    st_o = {word_t'(t1 + t2), st_i[0], st_i[1], st_i[2],
            word_t'(st_i[3] + t1), st_i[4], st_i[5], st_i[6]};
  end
endmodule

// File: rtl/sha256_two_block.sv
// Iterative two-block SHA-256 engine, one round per clock, 130-cycle accept-to-valid latency.
// Optional SHA256_TRACE_EN adds simulation-only display of accepted input and produced digest.
module sha256_two_block
  import sha256_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  sha256_two_block_if.slave bus
);
  state_e       state_q, state_d;
  hvec_t        h_q, h_d;
  hvec_t        wv_q, wv_d;
  hvec_t        out_q, out_d;
  sched_t       w_q, w_d;
  logic [511:0] blk1_q, blk1_d;
  logic [5:0]   t_q, t_d;

  hvec_t        round_st;
  hvec_t        h_sum;
  word_t        w_next;

  sha256_round u_round (
    .st_i (wv_q),
    .k_i  (K[t_q]),
    .w_i  (w_q[0]),
    .st_o (round_st)
  );

  // Next schedule word W_{t+16} and the end-of-block chaining sum.
  always_comb begin
    w_next = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];
    h_sum  = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[i] = h_q[i] + wv_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    wv_d    = wv_q;
    out_d   = out_q;
    w_d     = w_q;
    blk1_d  = blk1_q;
    t_d     = t_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_d     = bus.in[1023:512];
          blk1_d  = bus.in[511:0];
          h_d     = IV;
          wv_d    = IV;
          t_d     = 6'd0;
          state_d = ST_RUN0;
        end
      end
      ST_RUN0, ST_RUN1: begin
        wv_d = round_st;
        w_d  = {w_q[1:15], w_next};
        t_d  = t_q + 6'd1;
        if (t_q == 6'd63) begin
          state_d = (state_q == ST_RUN0) ? ST_ADD0 : ST_ADD1;
        end
      end
      ST_ADD0: begin
        h_d     = h_sum;
        wv_d    = h_sum;
        w_d     = blk1_q;
        t_d     = 6'd0;
        state_d = ST_RUN1;
      end
      ST_ADD1: begin
        h_d     = h_sum;
        out_d   = h_sum;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      wv_q    <= '0;
      out_q   <= '0;
      w_q     <= '0;
      blk1_q  <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      wv_q    <= wv_d;
      out_q   <= out_d;
      w_q     <= w_d;
      blk1_q  <= blk1_d;
      t_q     <= t_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out       = out_q;

`ifdef SHA256_TRACE_EN
  always @(posedge clk_i) begin
    if (rst_i) begin
      if (state_q == ST_IDLE && bus.in_valid) begin
        $display("sha256_two_block: accept in=%h", bus.in);
      end
      if (state_q == ST_ADD1) begin
        $display("sha256_two_block: digest=%h", h_sum);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_sha256_two_block.sv
// Scoreboard bench for sha256_two_block using the two-block "abcdbcde...nopq" vector.
module tb_sha256_two_block;
  localparam logic [255:0] KNOWN =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   hs_cyc;
  logic prev_ov;

  logic [255:0]  exp_q[$];
  int            acc_q[$];
  logic [447:0]  msg;
  logic [1023:0] vec;

  sha256_two_block_if bus();

  sha256_two_block dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: latency on out_valid rise, digest on every output handshake.
  initial begin
    prev_ov = 1'b0;
    hs_cyc  = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc + 1);
        if (bus.out_valid && !prev_ov) begin
          if (acc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL latency out_valid rose with no accepted input");
          end else begin
            chk("latency", 256'(cyc - acc_q.pop_front()), 256'd130);
          end
        end
        if (bus.out_valid && bus.out_ready) begin
          hs_cyc = cyc + 1;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL digest unexpected handshake actual=%0h", bus.out);
          end else begin
            chk("digest", bus.out, exp_q.pop_front());
          end
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic send(input logic [1023:0] v, input logic [255:0] e, output int acc);
    int n;
    exp_q.push_back(e);
    bus.in       = v;
    bus.in_valid = 1'b1;
    acc = -1;
    n   = 0;
    while (n < 400) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = cyc + 1;
        break;
      end
      n++;
    end
    if (acc < 0) begin
      checks++; errors++;
      $display("FAIL accept timeout actual=in_ready_low required=accept");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in       = ~v;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout actual=%0d_pending required=0", name, exp_q.size());
    end
  endtask

  initial begin
    int a1, a2, n;
    checks = 0;
    errors = 0;
    msg = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    vec = {msg, 8'h80, 504'h0, 64'h1c0};
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in        = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 256'(bus.in_ready), 256'd1);
    chk("rst_out_valid", 256'(bus.out_valid), 256'd0);
    chk("rst_out", bus.out, 256'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Known vector, consumer always ready.
    bus.out_ready = 1'b1;
    send(vec, KNOWN, a1);
    @(negedge clk);
    chk("busy_in_ready", 256'(bus.in_ready), 256'd0);
    chk("busy_out_valid", 256'(bus.out_valid), 256'd0);
    wait_done("known", 200);

    // Backpressure: hold the digest for 20 cycles.
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(vec, KNOWN, a1);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_seen", 256'(bus.out_valid), 256'd1);
    repeat (20) begin
      @(negedge clk);
      chk("bp_out", bus.out, KNOWN);
      chk("bp_out_valid", 256'(bus.out_valid), 256'd1);
      chk("bp_in_ready", 256'(bus.in_ready), 256'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_out_valid", 256'(bus.out_valid), 256'd0);
    chk("bp_after_in_ready", 256'(bus.in_ready), 256'd1);
    chk("bp_after_out_hold", bus.out, KNOWN);
    wait_done("backpressure", 10);

    // Busy input ignored and input changing after accept.
    @(posedge clk);
    #1;
    send(vec, KNOWN, a1);
    repeat (10) begin
      @(posedge clk);
      #1 bus.in = {32{$urandom()}};
    end
    bus.in_valid = 1'b1;
    bus.in       = ~vec;
    repeat (3) begin
      @(negedge clk);
      chk("ignored_in_ready", 256'(bus.in_ready), 256'd0);
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_done("busy_ignored", 200);

    // Reset in the middle of block 0.
    @(posedge clk);
    #1;
    send(vec, KNOWN, a1);
    repeat (50) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 256'(bus.in_ready), 256'd1);
    chk("midrst_out_valid", 256'(bus.out_valid), 256'd0);
    chk("midrst_out", bus.out, 256'd0);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(vec, KNOWN, a1);
    wait_done("after_reset", 200);

    // Back-to-back with out_ready tied high.
    @(posedge clk);
    #1;
    send(vec, KNOWN, a1);
    send(vec, KNOWN, a2);
    chk("b2b_gap", 256'(a2 - hs_cyc), 256'd1);
    wait_done("back_to_back", 200);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sha256_two_block.md
Name: sha256_two_block

Overview:
- Iterative SHA-256 compression engine that hashes exactly two 512-bit blocks, presented as one pre-padded 1024-bit word, and returns the 256-bit digest.
- Caller does all padding and length encoding.
- Used by the HMAC-SHA256 wrapper: an inner hash of (key^ipad || msg), then an outer hash of (key^opad || inner digest || pad).
- Valid/ready handshakes on both input and output sides.

Parameters:
- None. Width is fixed at 1024-bit input (2 blocks) and 256-bit output.

Ports:
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: in holds a message to hash.
- in, input, 1024: padded message, big-endian. in[1023:512] is block 0; W0 of block 0 is in[1023:992].
- in_ready, output, 1: engine idle and able to accept.
- out_valid, output, 1: digest valid.
- out, output, 256: digest. out[255:224] = H0 … out[31:0] = H7.
- out_ready, input, 1: consumer accepts the digest.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, out=0.
  - Round counter and working registers are cleared.
- States: IDLE → RUN0 → ADD0 → RUN1 → ADD1 → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&&in_ready: latch in, load H0..H7 with the FIPS 180-4 IV, load a..h with the IV, set t=0, go to RUN0.
- RUN0 / RUN1:
  - One SHA-256 round per cycle, t = 0..63.
  - W_t comes from a 16-word sliding schedule register. It is loaded from the current block at entry; for t≥16, W_t = σ1(W_{t-2}) + W_{t-7} + σ0(W_{t-15}) + W_{t-16}.
  - All additions are mod 2^32.
  - After t=63, go to ADDn.
- ADD0:
  - H_i += working var (mod 2^32).
  - a..h ← new H.
  - Schedule ← block 1; t=0; go to RUN1.
- ADD1:
  - H_i += working var.
  - out ← H.
  - out_valid=1 from the next cycle; go to DONE.
- Latency: out_valid asserts exactly 130 clock edges after the accepting edge (64+1+64+1).
- in_ready=0 in every state except IDLE; in_valid is ignored while busy.
- DONE:
  - out_valid=1 and out is held stable until out_valid&&out_ready.
  - On that edge: out_valid→0, go to IDLE (in_ready=1 the next cycle).
  - out keeps its last value after the handshake.
- out_ready while not in DONE: ignored, no effect.
- No back-to-back overlap: a new input is accepted at the earliest one cycle after the output handshake.
- Latched input is immune to changes on in after acceptance.
- Reset mid-hash aborts immediately with no output.

Optional Feature:
- Macro SHA256_TRACE_EN.
- Defined: simulation-only $display of the accepted 1024-bit input (hex) on acceptance, and of the digest when out_valid rises.
- Undefined: no display statements; identical cycle behaviour and synthesis result.

Decomposition:
- Package sha256_pkg holds:
  - K[0:63] round constants;
  - IV[0:7];
  - word type (32-bit);
  - state enum;
  - functions ch, maj, Σ0, Σ1, σ0, σ1.
- One sub-module, sha256_round: a combinational single round mapping (a..h, K_t, W_t) to the new a..h.
- Schedule, counter and FSM live in the top.

Test Plan:
- Known vector: in = padded "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (448-bit msg, 0x80 pad, length 0x1C0 in the last 64 bits) → out = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, with out_valid exactly 130 cycles after acceptance.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid → out and out_valid stable, in_ready=0. Raise out_ready → one-cycle handshake, then in_ready=1.
- Busy input ignored: pulse in_valid with a different value during RUN0 → no effect; the same digest as the known vector is produced.
- Input change after accept: alter in right after acceptance → digest unchanged.
- Reset mid-operation: assert rst_i=0 at cycle 50 of RUN0 → in_ready=1, out_valid=0 immediately. A fresh known-vector run then yields the correct digest.
- Back-to-back: two consecutive known-vector requests with out_ready tied high → two identical digests, the second accepted one cycle after the first handshake.
